// File: rtl/reset_button_conditioner_if.sv
// Board-side signal bundle for reset_button_conditioner.
// sw_reset_req exists only when SOFT_RESET_EN is defined.
interface reset_button_conditioner_if #(
  parameter int NUM_INPUTS = 1
);
  logic [NUM_INPUTS-1:0] btn_in;
  logic [NUM_INPUTS-1:0] btn_level;
  logic [NUM_INPUTS-1:0] btn_press;
  logic [NUM_INPUTS-1:0] btn_release;
  logic                  soc_reset;
  logic                  soc_reset_n;
`ifdef SOFT_RESET_EN
  logic                  sw_reset_req;

  modport master (output btn_in, sw_reset_req,
                  input  btn_level, btn_press, btn_release, soc_reset, soc_reset_n);
  modport slave  (input  btn_in, sw_reset_req,
                  output btn_level, btn_press, btn_release, soc_reset, soc_reset_n);
`else
  modport master (output btn_in,
                  input  btn_level, btn_press, btn_release, soc_reset, soc_reset_n);
  modport slave  (input  btn_in,
                  output btn_level, btn_press, btn_release, soc_reset, soc_reset_n);
`endif
endinterface

// File: rtl/reset_button_conditioner.sv
// Button synchroniser/debouncer array plus power-on / button-driven SOC reset FSM.
// Optional SOFT_RESET_EN adds a software reset request path from RUN.
module rbc_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync  <= {sync[0], pin ^ ACTIVE_LOW};
      press <= 1'b0;
      rel   <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // Level, pulse and counter clear all land on the same edge.
        level <= ~level;
        cnt   <= '0;
        press <= ~level;
        rel   <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module reset_button_conditioner #(
  parameter int CLOCK_FREQ       = 25000000,
  parameter int NUM_INPUTS       = 1,
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int POR_CYCLES       = 1024,
  parameter int STRETCH_CYCLES   = 16,
  parameter int RESET_INPUT      = 0,
  parameter int INPUT_ACTIVE_LOW = 0
) (
  input logic                       clk,
  input logic                       reset,
  reset_button_conditioner_if.slave bus
);
  localparam int PW = $clog2(POR_CYCLES + 1);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);

  if (NUM_INPUTS < 1 || NUM_INPUTS > 8) begin : g_bad_n
    $error("NUM_INPUTS must be 1..8");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (POR_CYCLES < 1 || STRETCH_CYCLES < 1) begin : g_bad_cyc
    $error("POR_CYCLES and STRETCH_CYCLES must be >= 1");
  end
  if (RESET_INPUT < 0 || RESET_INPUT >= NUM_INPUTS) begin : g_bad_ri
    $error("RESET_INPUT must index an existing channel");
  end

  typedef enum logic [1:0] {ST_POR, ST_RUN, ST_HOLD, ST_STRETCH} state_t;

  logic [NUM_INPUTS-1:0] pin_raw, lvl, prs, rls;

  assign pin_raw = bus.btn_in;

  rbc_debounce_lane #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (INPUT_ACTIVE_LOW != 0)
  ) u_lane [NUM_INPUTS-1:0] (
    .clk   (clk),
    .reset (reset),
    .pin   (pin_raw),
    .level (lvl),
    .press (prs),
    .rel   (rls)
  );

  assign bus.btn_level   = lvl;
  assign bus.btn_press   = prs;
  assign bus.btn_release = rls;

  state_t        state, state_nxt;
  logic [PW-1:0] por_cnt, por_cnt_nxt;
  logic [SW-1:0] str_cnt, str_cnt_nxt;
  logic          soc_q;
  logic          sw_req;

`ifdef SOFT_RESET_EN
  assign sw_req = bus.sw_reset_req;
`else
  assign sw_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_POR;
      por_cnt <= '0;
      str_cnt <= '0;
      soc_q   <= 1'b1;
    end else begin
      state   <= state_nxt;
      por_cnt <= por_cnt_nxt;
      str_cnt <= str_cnt_nxt;
      // Registered from next state so the SOC never sees a combinational glitch.
      soc_q   <= (state_nxt != ST_RUN);
    end
  end

  always_comb begin
    state_nxt   = state;
    por_cnt_nxt = por_cnt;
    str_cnt_nxt = str_cnt;
    unique case (state)
      ST_POR: begin
        if (por_cnt == PW'(POR_CYCLES)) state_nxt = lvl[RESET_INPUT] ? ST_HOLD : ST_RUN;
        else                            por_cnt_nxt = por_cnt + 1'b1;
      end
      ST_RUN: begin
        if (prs[RESET_INPUT]) begin
          state_nxt = ST_HOLD;
        end else if (sw_req) begin
          state_nxt   = ST_STRETCH;
          str_cnt_nxt = '0;
        end
      end
      ST_HOLD: begin
        if (rls[RESET_INPUT]) begin
          state_nxt   = ST_STRETCH;
          str_cnt_nxt = '0;
        end
      end
      ST_STRETCH: begin
        if (prs[RESET_INPUT])                        state_nxt = ST_HOLD;
        else if (str_cnt == SW'(STRETCH_CYCLES - 1)) state_nxt = ST_RUN;
        else                                         str_cnt_nxt = str_cnt + 1'b1;
      end
      default: state_nxt = ST_POR;
    endcase
  end

  assign bus.soc_reset   = soc_q;
  assign bus.soc_reset_n = ~soc_q;

  a_press_rel_excl: assert property (@(posedge clk) disable iff (!reset) !(|(prs & rls)))
    else $error("press/release overlap (clock %0d Hz)", CLOCK_FREQ);
endmodule

// File: tb/tb_reset_button_conditioner.sv
// Scoreboard bench: expected pulse/edge cycles queued at stimulus time, matched by a negedge monitor.
// A second long-stretch, active-low instance exercises re-press during STRETCH.
module tb_reset_button_conditioner;
  localparam int EV_PRESS0 = 0, EV_PRESS1 = 1, EV_REL0 = 2, EV_REL1 = 3, EV_RISE = 4, EV_FALL = 5;

  typedef struct {int kind; int cyc;} ev_t;

  logic  clk = 1'b0;
  logic  reset = 1'b0;
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;
  logic  prev_soc = 1'b1;
  ev_t   sb_q[$];
  string knm[6] = '{"press0", "press1", "release0", "release1", "soc_rise", "soc_fall"};

  reset_button_conditioner_if #(.NUM_INPUTS(2)) bif ();
  reset_button_conditioner_if #(.NUM_INPUTS(1)) bif2 ();

  reset_button_conditioner #(
    .CLOCK_FREQ(25000000), .NUM_INPUTS(2), .DEBOUNCE_CYCLES(8), .POR_CYCLES(16),
    .STRETCH_CYCLES(4), .RESET_INPUT(0), .INPUT_ACTIVE_LOW(0)
  ) u_dut (.clk(clk), .reset(reset), .bus(bif.slave));

  reset_button_conditioner #(
    .CLOCK_FREQ(25000000), .NUM_INPUTS(1), .DEBOUNCE_CYCLES(8), .POR_CYCLES(16),
    .STRETCH_CYCLES(16), .RESET_INPUT(0), .INPUT_ACTIVE_LOW(1)
  ) u_dut_long (.clk(clk), .reset(reset), .bus(bif2.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic push(input int kind, input int c);
    sb_q.push_back('{kind, c});
  endtask

  task automatic observe(input int kind);
    int idx = -1;
    foreach (sb_q[i]) if (idx < 0 && sb_q[i].kind == kind) idx = i;
    if (idx >= 0) begin
      chk(knm[kind], cyc, sb_q[idx].cyc);
      sb_q.delete(idx);
    end else begin
      chk({"unexpected_", knm[kind]}, cyc, -1);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("press_rel_excl", int'(bif.btn_press & bif.btn_release), 0);
      for (int ch = 0; ch < 2; ch++) begin
        if (bif.btn_press[ch])   observe(EV_PRESS0 + ch);
        if (bif.btn_release[ch]) observe(EV_REL0 + ch);
      end
      if (bif.soc_reset && !prev_soc) observe(EV_RISE);
      if (!bif.soc_reset && prev_soc) observe(EV_FALL);
    end
    prev_soc = bif.soc_reset;
  end

  initial begin
    int first_low, repress, rel2;
    bif.btn_in  = 2'b00;
    bif2.btn_in = 1'b1;
`ifdef SOFT_RESET_EN
    bif.sw_reset_req  = 1'b0;
    bif2.sw_reset_req = 1'b0;
`endif
    step(1);
    mon_en = 1'b1;

    // Power-on: reset low through cycle 5
    step(4);
    chk("rst_soc_reset",   int'(bif.soc_reset), 1);
    chk("rst_soc_reset_n", int'(bif.soc_reset_n), 0);
    chk("rst_btn_level",   int'(bif.btn_level), 0);
    chk("rst_btn_press",   int'(bif.btn_press), 0);
    chk("rst_btn_release", int'(bif.btn_release), 0);
    reset = 1'b1;
    push(EV_FALL, cyc + 17);
    step(16);
    chk("por_level_idle", int'(bif.btn_level), 0);
    chk("por2_still_high", int'(bif2.soc_reset), 1);
    step(1);
    chk("por2_fall", int'(bif2.soc_reset), 0);

    // Clean press/release on channel 1
    step(8);
    bif.btn_in[1] = 1'b1;
    push(EV_PRESS1, cyc + 10);
    step(11);
    chk("ch1_level", int'(bif.btn_level), 2);
    chk("ch1_soc_low", int'(bif.soc_reset), 0);
    bif.btn_in[1] = 1'b0;
    push(EV_REL1, cyc + 10);
    step(12);

    // Bounce on channel 0, then held 40 cycles as the reset button
    for (int i = 0; i < 10; i++) begin
      bif.btn_in[0] = ~bif.btn_in[0];
      step(3);
    end
    bif.btn_in[0] = 1'b1;
    push(EV_PRESS0, cyc + 10);
    push(EV_RISE,   cyc + 11);
    step(40);
    chk("hold_level", int'(bif.btn_level), 1);
    chk("hold_soc_n", int'(bif.soc_reset_n), 0);
    bif.btn_in[0] = 1'b0;
    push(EV_REL0, cyc + 10);
    push(EV_FALL, cyc + 15);
    step(20);
    chk("after_stretch_soc", int'(bif.soc_reset), 0);

    // Re-press during STRETCH on the long-stretch, active-low instance
    bif2.btn_in = 1'b0;
    first_low = -1; repress = -1; rel2 = -1;
    for (int k = 1; k <= 100; k++) begin
      step(1);
      if (k == 20) bif2.btn_in = 1'b1;
      if (k == 30) bif2.btn_in = 1'b0;
      if (k == 60) bif2.btn_in = 1'b1;
      if (bif2.btn_release[0] && rel2 < 0) rel2 = k;
      if (bif2.btn_press[0] && k > 25 && repress < 0) repress = k;
      if (!bif2.soc_reset && k >= 11 && first_low < 0) first_low = k;
    end
    chk("long_release", rel2, 30);
    chk("long_repress", repress, 40);
    chk("long_soc_fall", first_low, 87);

    // Reset asserted mid-debounce on channel 1
    step(2);
    bif.btn_in[1] = 1'b1;
    step(5);
    reset = 1'b0;
    push(EV_RISE, cyc + 1);
    step(1);
    chk("midrst_level",   int'(bif.btn_level), 0);
    chk("midrst_press",   int'(bif.btn_press), 0);
    chk("midrst_release", int'(bif.btn_release), 0);
    chk("midrst_soc",     int'(bif.soc_reset), 1);
    chk("midrst_soc_n",   int'(bif.soc_reset_n), 0);
    bif.btn_in[1] = 1'b0;
    step(3);
    reset = 1'b1;
    push(EV_FALL, cyc + 17);
`ifdef SOFT_RESET_EN
    step(3);
    bif.sw_reset_req = 1'b1;
    step(1);
    bif.sw_reset_req = 1'b0;
    step(22);
    bif.sw_reset_req = 1'b1;
    push(EV_RISE, cyc + 1);
    push(EV_FALL, cyc + 5);
    step(1);
    bif.sw_reset_req = 1'b0;
    step(10);
`else
    step(30);
`endif
    chk("final_soc_n", int'(bif.soc_reset_n), 1);
    step(3);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reset_button_conditioner.md
# reset_button_conditioner

Parametrised reset and button conditioner for FPGA top-level wrappers. It synchronises and debounces NUM_INPUTS raw board buttons, generates a power-on reset, and drives a stretched active-high reset into the Risco_5_SOC from one selected button. It sits directly between the board pins and the SOC instance in every board top, and replaces ad-hoc single-flop reset registering.

## Interface
- CLOCK_FREQ, 25000000: clock frequency in Hz; informational, used only for assertion messages.
- NUM_INPUTS, 1: number of button channels, 1 to 8.
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required to accept a level change; must be at least 2.
- POR_CYCLES, 1024: cycles `soc_reset` is held after `reset` deasserts; must be at least 1.
- STRETCH_CYCLES, 16: minimum `soc_reset` high time after a button release; must be at least 1.
- RESET_INPUT, 0: index of the channel that drives `soc_reset`.
- INPUT_ACTIVE_LOW, 0: when 1, every `btn_in` bit is inverted before synchronisation.

Ports:
- clk, input, 1: single clock; all logic is on its rising edge.
- reset, input, 1: synchronous, active-low reset.
- btn_in, input, NUM_INPUTS: raw asynchronous button pins.
- btn_level, output, NUM_INPUTS: debounced level, 1 = pressed.
- btn_press, output, NUM_INPUTS: one-cycle pulse on debounced press.
- btn_release, output, NUM_INPUTS: one-cycle pulse on debounced release.
- soc_reset, output, 1: active-high reset to the SOC.
- soc_reset_n, output, 1: always the inverse of `soc_reset`.
- sw_reset_req, input, 1: present only with SOFT_RESET_EN.

## Operation
- Per channel:
  - Optional inversion, then a 2-flop synchroniser (`sync`).
  - A counter of width $clog2(DEBOUNCE_CYCLES).
  - Counter rules, each cycle:
    - `sync == btn_level`: counter clears.
    - `sync != btn_level` and counter < DEBOUNCE_CYCLES-1: counter increments.
    - `sync != btn_level` and counter == DEBOUNCE_CYCLES-1: `btn_level` toggles, counter clears, and the matching press or release pulse asserts for exactly one cycle.
  - A glitch shorter than DEBOUNCE_CYCLES never changes `btn_level`.
- Reset FSM, states POR, RUN, HOLD, STRETCH:
  - POR: `soc_reset`=1. A counter of width $clog2(POR_CYCLES+1) counts up. At count POR_CYCLES the FSM goes to HOLD if `btn_level[RESET_INPUT]`=1, otherwise to RUN.
  - RUN: `soc_reset`=0. Goes to HOLD on `btn_press[RESET_INPUT]`.
  - HOLD: `soc_reset`=1 while `btn_level[RESET_INPUT]`=1. On `btn_release[RESET_INPUT]` it clears the stretch counter and goes to STRETCH.
  - STRETCH: `soc_reset`=1. Counts to STRETCH_CYCLES-1 and then goes to RUN. A press during STRETCH returns the FSM to HOLD, and the new press takes priority.
- `soc_reset` is registered and is a function of the next state, so it has no glitches.
- Other channels have no effect on `soc_reset`.

## Timing
- While `reset`=0:
  - All synchronisers, counters and `btn_level` are 0.
  - `btn_press` and `btn_release` are 0.
  - `soc_reset`=1 and `soc_reset_n`=0.
  - The state is POR.
- `reset` is sampled only at clk edges. Asserting it mid-debounce or mid-stretch aborts all activity on the next edge.
- Pin edge to `btn_level` change: 2 + DEBOUNCE_CYCLES cycles for a clean edge. The pulse is coincident with the level change.
- `reset` rising to `soc_reset` falling: POR_CYCLES+1 cycles, with no button held.
- `btn_level[RESET_INPUT]` 1→0 to `soc_reset` falling: STRETCH_CYCLES+1 cycles.
- `btn_press` and `btn_release` are mutually exclusive per channel per cycle.

## Configuration
- SOFT_RESET_EN defined:
  - Adds input `sw_reset_req` (synchronous, from SOC logic).
  - A 1 seen in RUN moves the FSM to STRETCH, giving a STRETCH_CYCLES reset pulse.
  - The request is ignored in POR, HOLD and STRETCH.
  - If a request and a reset-button press occur in the same cycle, the press wins and the FSM goes to HOLD.
- SOFT_RESET_EN undefined: the port is absent and the FSM has no software path.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8, POR_CYCLES=16, STRETCH_CYCLES=4, NUM_INPUTS=2, RESET_INPUT=0.
- Power-on:
  - Stimulus: `reset` low for 5 cycles, then high, buttons idle.
  - Required: `soc_reset`=1 through cycle 16 after release and 0 from cycle 17; `btn_level`=00 throughout.
- Clean press on channel 1 in RUN:
  - Required: `btn_level[1]` rises exactly 10 cycles after the pin edge, with a single-cycle `btn_press[1]`.
  - Required: `soc_reset` stays 0.
- Bounce:
  - Stimulus: `btn_in[0]` toggles every 3 cycles for 30 cycles, then holds 1.
  - Required: one `btn_press[0]` only, 10 cycles after the final edge.
- Reset button:
  - Stimulus: hold `btn_in[0]` for 40 cycles, then release.
  - Required: `soc_reset` rises with `btn_press[0]`, stays high while held, and falls 5 cycles after `btn_release[0]`.
- Re-press during STRETCH, and reset mid-operation:
  - Re-press during STRETCH: FSM returns to HOLD and `soc_reset` never drops.
  - Reset mid-operation: drop `reset` during a debounce count. All outputs reach their reset values on the next edge.
- SOFT_RESET_EN:
  - Stimulus: pulse `sw_reset_req` for 1 cycle in RUN.
  - Required: `soc_reset` high for exactly 4 cycles.
  - Stimulus: the same pulse during POR. Required: no effect.
